// File: rtl/note_sequencer_if.sv
// Host-side control and score-write bus for note_sequencer, plus its playback outputs.
interface note_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic              stop;
    logic              loop;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic [15:0]       phase_divider;
    logic              gate;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] step;

    modport master (
        output start, stop, loop, wr_en, wr_addr, wr_data,
        input  phase_divider, gate, busy, done, step
    );

    modport slave (
        input  start, stop, loop, wr_en, wr_addr, wr_data,
        output phase_divider, gate, busy, done, step
    );
endinterface

// File: rtl/note_sequencer.sv
// Score-driven tone controller: steps through a writable (divider, duration) score,
// driving phase_divider and gate for each note with tick-prescaled timing.
module note_sequencer #(
    parameter int STEPS     = 16,
    parameter int ADDR_W    = 4,
    parameter int TICK_DIV  = 480000,
    parameter int GAP_TICKS = 1
) (
    input logic             clk48m,
    input logic             rst,
    note_sequencer_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] step_q, step_d;
    logic [15:0]       div_q, div_d;
    logic              gate_q, gate_d;
    logic              done_q, done_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [7:0]        ticks_q, ticks_d;
    logic              finish;

    logic [23:0]       mem [STEPS];
    logic [23:0]       rd_q;
    logic [15:0]       rd_div;
    logic [7:0]        rd_dur;
    logic              tick_end;
    logic              last_step;

    assign rd_div    = rd_q[23:8];
    assign rd_dur    = rd_q[7:0];
    assign tick_end  = (presc_q == PW'(TICK_DIV - 1));
    assign last_step = (step_q == ADDR_W'(STEPS - 1));

    // Score memory: unreset, synchronous read during FETCH, read-before-write on collision.
    always_ff @(posedge clk48m) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
        if (state_q == S_FETCH) begin
            rd_q <= mem[step_q];
        end
    end

    // State and output registers.
    always_ff @(posedge clk48m or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            div_q   <= '0;
            gate_q  <= 1'b0;
            done_q  <= 1'b0;
            presc_q <= '0;
            ticks_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            div_q   <= div_d;
            gate_q  <= gate_d;
            done_q  <= done_d;
            presc_q <= presc_d;
            ticks_q <= ticks_d;
        end
    end

    // Next-state logic; ticks_q counts remaining ticks, so gate is high while more than
    // GAP_TICKS remain, and gate/divider hold through FETCH/LOAD to avoid glitches.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        div_d   = div_q;
        gate_d  = gate_q;
        done_d  = 1'b0;
        presc_d = presc_q;
        ticks_d = ticks_q;
        finish  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    step_d  = '0;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (rd_dur == 8'd0) begin
                    if (bus.loop && (step_q != '0)) begin
                        step_d  = '0;
                        state_d = S_FETCH;
                    end else begin
                        finish = 1'b1;
                    end
                end else begin
                    div_d   = rd_div;
                    ticks_d = rd_dur;
                    presc_d = '0;
                    gate_d  = (rd_div != 16'd0) && (int'(rd_dur) > GAP_TICKS);
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tick_end) begin
                    presc_d = '0;
                    ticks_d = ticks_q - 8'd1;
                    if (ticks_q == 8'd1) begin
                        if (!last_step) begin
                            step_d  = step_q + 1'b1;
                            state_d = S_FETCH;
                        end else if (bus.loop) begin
                            step_d  = '0;
                            state_d = S_FETCH;
                        end else begin
                            finish = 1'b1;
                        end
                    end else begin
                        gate_d = (div_q != 16'd0) && ((int'(ticks_q) - 1) > GAP_TICKS);
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (finish) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            step_d  = '0;
            div_d   = '0;
            gate_d  = 1'b0;
            presc_d = '0;
            ticks_d = '0;
        end

        if (bus.stop) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            step_d  = '0;
            div_d   = '0;
            gate_d  = 1'b0;
            presc_d = '0;
            ticks_d = '0;
        end
    end

    assign bus.phase_divider = div_q;
    assign bus.gate          = gate_q;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = done_q;
    assign bus.step          = step_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: table of score scenarios expanded into a per-cycle expected
// timeline (scoreboard queue), plus hand-written stop/reset/collision sequences.
module tb_note_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;

    note_sequencer_if #(.ADDR_W(2)) bus ();

    note_sequencer #(
        .STEPS    (4),
        .ADDR_W   (2),
        .TICK_DIV (4),
        .GAP_TICKS(1)
    ) dut (
        .clk48m(clk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pd;
        logic        gate;
        logic        busy;
        logic        done;
        logic [1:0]  step;
    } exp_t;

    typedef struct {
        string            name;
        logic [3:0][23:0] e;
        logic             lp;
        int               limit;
        int               poke;
        logic             coll;
        logic [23:0]      cdata;
    } case_t;

    exp_t  q[$];
    int    checks = 0;
    int    errors = 0;
    case_t cases[7];

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input exp_t e);
        checks++;
        if (bus.phase_divider !== e.pd || bus.gate !== e.gate || bus.busy !== e.busy ||
            bus.done !== e.done || bus.step !== e.step) begin
            errors++;
            $display("FAIL %s t=%0t: got pd=%h gate=%b busy=%b done=%b step=%0d, want pd=%h gate=%b busy=%b done=%b step=%0d",
                     name, $time, bus.phase_divider, bus.gate, bus.busy, bus.done, bus.step,
                     e.pd, e.gate, e.busy, e.done, e.step);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] pd, input logic g, input logic b,
                                input logic d, input int s);
        exp_t r;
        r.pd = pd; r.gate = g; r.busy = b; r.done = d; r.step = 2'(s);
        return r;
    endfunction

    // Expected timeline: 2 hold cycles per entry, duration*4 play cycles, gate while
    // elapsed ticks < duration - 1, then a done cycle and an idle cycle.
    task automatic gen(input logic [3:0][23:0] sc_in, input logic lp, input int limit,
                       input logic coll, input logic [23:0] cdata, output int fetch1);
        logic [3:0][23:0] sc;
        logic [15:0] pd, dv;
        logic        g, used1;
        int          s, dur;
        sc = sc_in; pd = '0; g = 1'b0; s = 0; fetch1 = -1; used1 = 1'b0;
        forever begin
            if (q.size() >= limit) break;
            if (s == 1 && fetch1 < 0) fetch1 = q.size();
            q.push_back(mk(pd, g, 1'b1, 1'b0, s));
            q.push_back(mk(pd, g, 1'b1, 1'b0, s));
            dur = int'(sc[s][7:0]);
            dv  = sc[s][23:8];
            if (s == 1 && coll && !used1) begin
                used1 = 1'b1;
                sc[1] = cdata;
            end
            if (dur == 0) begin
                if (lp && s != 0) begin
                    s = 0;
                    continue;
                end
                q.push_back(mk('0, 1'b0, 1'b0, 1'b1, 0));
                q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 0));
                break;
            end
            for (int c = 0; c < dur * 4; c++) begin
                pd = dv;
                g  = (dv != 16'd0) && ((c / 4) < (dur - 1));
                q.push_back(mk(pd, g, 1'b1, 1'b0, s));
            end
            if (s < 3) s++;
            else if (lp) s = 0;
            else begin
                q.push_back(mk('0, 1'b0, 1'b0, 1'b1, 0));
                q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 0));
                break;
            end
        end
    endtask

    task automatic write_entry(input int a, input logic [23:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'(a);
        bus.wr_data = d;
        cycle();
        bus.wr_en   = 1'b0;
    endtask

    task automatic run_case(input case_t c, input bit do_write);
        int   f1, idx;
        exp_t e;
        logic last_busy;
        if (do_write) begin
            for (int i = 0; i < 4; i++) write_entry(i, c.e[i]);
        end
        q.delete();
        gen(c.e, c.lp, c.limit, c.coll, c.cdata, f1);
        bus.loop  = c.lp;
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        idx = 0;
        last_busy = 1'b0;
        while (q.size() > 0) begin
            e = q.pop_front();
            check(c.name, e);
            last_busy = e.busy;
            bus.start = (idx == c.poke);
            if (c.coll && idx == f1) begin
                bus.wr_en = 1'b1; bus.wr_addr = 2'd1; bus.wr_data = c.cdata;
            end else begin
                bus.wr_en = 1'b0;
            end
            idx++;
            if (q.size() > 0) cycle();
        end
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        if (last_busy) begin
            bus.stop = 1'b1;
            cycle();
            bus.stop = 1'b0;
            for (int i = 0; i < 3; i++) begin
                check({c.name, "_stop"}, mk('0, 1'b0, 1'b0, 1'b0, 0));
                cycle();
            end
        end
        bus.loop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cases[0] = '{"basic", {24'h000000, 24'h0BCD01, 24'h000002, 24'h123403}, 1'b0, 1000, -1, 1'b0, 24'h0};
        cases[1] = '{"loop_marker", {24'h000000, 24'h0BCD01, 24'h000002, 24'h123403}, 1'b1, 50, -1, 1'b0, 24'h0};
        cases[2] = '{"full_len", {24'h7FFF02, 24'h0ABC01, 24'h000001, 24'h010002}, 1'b0, 1000, -1, 1'b0, 24'h0};
        cases[3] = '{"stop_mid", {24'h000000, 24'h0BCD01, 24'h000002, 24'h123403}, 1'b0, 6, -1, 1'b0, 24'h0};
        cases[4] = '{"start_busy", {24'h000000, 24'h0BCD01, 24'h000002, 24'h123403}, 1'b0, 1000, 10, 1'b0, 24'h0};
        cases[5] = '{"wr_collide", {24'h000000, 24'h333301, 24'h222202, 24'h111101}, 1'b1, 60, -1, 1'b1, 24'h444403};
        cases[6] = '{"marker_at0", {24'h0BCD01, 24'h000002, 24'h123403, 24'h555500}, 1'b1, 1000, -1, 1'b0, 24'h0};

        bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        #1 rst = 1'b1;
        #11;
        check("reset_state", mk('0, 1'b0, 1'b0, 1'b0, 0));
        @(negedge clk);
        rst = 1'b0;
        cycle();

        foreach (cases[i]) run_case(cases[i], 1'b1);

        // start and stop together from IDLE: stop wins
        bus.start = 1'b1; bus.stop = 1'b1;
        cycle();
        bus.start = 1'b0; bus.stop = 1'b0;
        check("start_stop", mk('0, 1'b0, 1'b0, 1'b0, 0));
        cycle();
        check("start_stop_hold", mk('0, 1'b0, 1'b0, 1'b0, 0));

        // asynchronous reset in the middle of a gated note, away from any clock edge
        for (int i = 0; i < 4; i++) write_entry(i, cases[0].e[i]);
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        check("pre_reset", mk(16'h1234, 1'b1, 1'b1, 1'b0, 0));
        #1 rst = 1'b1;
        #1;
        check("async_reset", mk('0, 1'b0, 1'b0, 1'b0, 0));
        @(negedge clk);
        rst = 1'b0;
        cycle();
        // score survives reset
        run_case(cases[0], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
